// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command sequencer.
// Commands travel through the FIFO as one packed word.
package calc_pkg;

  localparam int OPERAND_W = 8;
  localparam int RESULT_W  = 16;
  localparam int TAG_W     = 4;

  localparam logic [RESULT_W-1:0] DIV0_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    op_e                  op;
    logic [TAG_W-1:0]     tag;
  } cmd_t;

  // A zero divisor is answered locally and never reaches the calculator.
  function automatic logic is_div0(input cmd_t c);
    return (c.op == OP_DIV) && (c.b == '0);
  endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// In-order synchronous FIFO of calculator commands.
// DEPTH must be a power of two so the pointers wrap naturally.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output cmd_t                     head
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Command front-end for the registered 8-bit calculator: queues commands,
// issues them one at a time and returns tagged results.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_tag,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_q,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err,
  output logic        busy
);

  state_e                       state;
  cmd_t                         push_cmd;
  cmd_t                         head;
  logic                         full;
  logic                         empty;
  logic [$clog2(FIFO_DEPTH):0]  count;
  logic                         push;
  logic                         pop;
  logic [3:0]                   cur_tag;

  assign push_cmd  = '{a: cmd_a, b: cmd_b, op: op_e'(cmd_op), tag: cmd_tag};
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = !reset && ((state != ST_IDLE) || (count != '0));

  // A RESP handshake pops the next command in the same cycle to keep 3-cycle throughput.
  assign pop = !empty && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));

  calc_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      cur_tag   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if ((state == ST_IDLE) || rsp_ready) begin
            if (pop) begin
              if (is_div0(head)) begin
                rsp_valid <= 1'b1;
                rsp_data  <= DIV0_RESULT;
                rsp_tag   <= head.tag;
                rsp_err   <= 1'b1;
                state     <= ST_RESP;
              end else begin
                alu_a     <= head.a;
                alu_b     <= head.b;
                alu_op    <= head.op;
                cur_tag   <= head.tag;
                rsp_valid <= 1'b0;
                state     <= ST_ISSUE;
              end
            end else begin
              rsp_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= alu_q;
          rsp_tag   <= cur_tag;
          rsp_err   <= 1'b0;
          state     <= ST_RESP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural registered calculator
// as its ALU; expected results are hand-computed constants.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_q;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    logic        err;
    int          cyc;
  } rsp_rec_t;

  rsp_rec_t rsp_q[$];
  rsp_rec_t rec;
  int       cyc = 0;
  int       vectors = 0;
  int       miscompares = 0;
  int       rd_idx = 0;
  int       accept_cyc = 0;

  always #5 clk = ~clk;

  calc_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_tag   (cmd_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_q     (alu_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Registered calculator on the same clock and reset
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q <= '0;
    end else begin
      case (alu_op)
        2'b00:   alu_q <= {8'd0, alu_a} + {8'd0, alu_b};
        2'b01:   alu_q <= {8'd0, alu_a} - {8'd0, alu_b};
        2'b10:   alu_q <= {8'd0, alu_a} * {8'd0, alu_b};
        default: alu_q <= (alu_b == 8'd0) ? DIV0_RESULT : {8'd0, alu_a / alu_b};
      endcase
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded mid-cycle, tagged with the cycle the response was visible
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      rec.data = rsp_data;
      rec.tag  = rsp_tag;
      rec.err  = rsp_err;
      rec.cyc  = cyc;
      rsp_q.push_back(rec);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] op, input logic [3:0] tag);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      tick();
      accept_cyc = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic waitResponses(input int n);
    int waited = 0;
    while (rsp_q.size() < rd_idx + n && waited < 200) begin
      tick();
      waited++;
    end
    if (rsp_q.size() < rd_idx + n) begin
      checkOutput("rsp_timeout", 32'(rsp_q.size()), 32'(rd_idx + n));
    end
  endtask

  task automatic expectRsp(input string name, input logic [15:0] data, input logic [3:0] tag,
                           input logic err, output int rcyc);
    rcyc = 0;
    if (rd_idx < rsp_q.size()) begin
      checkOutput({name, "_data"}, 32'(rsp_q[rd_idx].data), 32'(data));
      checkOutput({name, "_tag"},  32'(rsp_q[rd_idx].tag),  32'(tag));
      checkOutput({name, "_err"},  32'(rsp_q[rd_idx].err),  32'(err));
      rcyc = rsp_q[rd_idx].cyc;
      rd_idx++;
    end else begin
      checkOutput({name, "_missing"}, 32'(rsp_q.size()), 32'(rd_idx + 1));
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, "_rsp_data"},  32'(rsp_data),  32'd0);
    checkOutput({name, "_rsp_tag"},   32'(rsp_tag),   32'd0);
    checkOutput({name, "_rsp_err"},   32'(rsp_err),   32'd0);
    checkOutput({name, "_alu_a"},     32'(alu_a),     32'd0);
    checkOutput({name, "_alu_b"},     32'(alu_b),     32'd0);
    checkOutput({name, "_alu_op"},    32'(alu_op),    32'd0);
    checkOutput({name, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    int c1, c2, c3, c4, c5, start_cyc, release_cyc, qsize;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    checkAllZero("reset");
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single add: 200 + 100 = 300, three cycles after accept
    $display("[TB] single add");
    rsp_ready = 1'b1;
    applyStimulus(8'd200, 8'd100, 2'b00, 4'd3);
    start_cyc = accept_cyc;
    tick();
    checkOutput("add_alu_a",  32'(alu_a),  32'd200);
    checkOutput("add_alu_b",  32'(alu_b),  32'd100);
    checkOutput("add_alu_op", 32'(alu_op), 32'd0);
    waitResponses(1);
    expectRsp("add", 16'd300, 4'd3, 1'b0, c1);
    checkOutput("add_latency", 32'(c1 - start_cyc), 32'd3);

    // Sub then mul, in order
    $display("[TB] sub and mul");
    applyStimulus(8'd3, 8'd5, 2'b01, 4'd1);
    start_cyc = accept_cyc;
    applyStimulus(8'd255, 8'd255, 2'b10, 4'd2);
    waitResponses(2);
    expectRsp("sub", 16'hFFFE, 4'd1, 1'b0, c1);
    expectRsp("mul", 16'hFE01, 4'd2, 1'b0, c2);
    checkOutput("sub_latency", 32'(c1 - start_cyc), 32'd3);
    checkOutput("mul_gap",     32'(c2 - c1),        32'd3);

    // Divide-by-zero answered locally, then a real divide
    $display("[TB] divide by zero");
    applyStimulus(8'd9, 8'd0, 2'b11, 4'd7);
    start_cyc = accept_cyc;
    applyStimulus(8'd9, 8'd2, 2'b11, 4'd8);
    checkOutput("div0_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("div0_alu_a",     32'(alu_a),     32'd255);
    checkOutput("div0_alu_b",     32'(alu_b),     32'd255);
    checkOutput("div0_alu_op",    32'(alu_op),    32'd2);
    waitResponses(2);
    expectRsp("div0", 16'hFFFF, 4'd7, 1'b1, c1);
    expectRsp("div",  16'd4,    4'd8, 1'b0, c2);
    checkOutput("div0_latency", 32'(c1 - start_cyc), 32'd1);
    checkOutput("div_gap",      32'(c2 - c1),        32'd3);

    // Backpressure: 5 commands with rsp_ready low
    $display("[TB] backpressure");
    repeat (2) tick();
    rsp_ready = 1'b0;
    applyStimulus(8'd1,   8'd2,   2'b00, 4'd9);
    applyStimulus(8'd10,  8'd4,   2'b01, 4'd10);
    applyStimulus(8'd16,  8'd16,  2'b10, 4'd11);
    applyStimulus(8'd100, 8'd7,   2'b11, 4'd12);
    applyStimulus(8'd255, 8'd255, 2'b00, 4'd13);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_data",  32'(rsp_data),  32'd3);
      checkOutput("bp_rsp_tag",   32'(rsp_tag),   32'd9);
      checkOutput("bp_busy",      32'(busy),      32'd1);
      tick();
    end
    rsp_ready   = 1'b1;
    release_cyc = cyc;
    waitResponses(5);
    expectRsp("bp1", 16'd3,   4'd9,  1'b0, c1);
    expectRsp("bp2", 16'd6,   4'd10, 1'b0, c2);
    expectRsp("bp3", 16'd256, 4'd11, 1'b0, c3);
    expectRsp("bp4", 16'd14,  4'd12, 1'b0, c4);
    expectRsp("bp5", 16'd510, 4'd13, 1'b0, c5);
    checkOutput("bp1_cycle", 32'(c1 - release_cyc), 32'd0);
    checkOutput("bp2_gap",   32'(c2 - c1), 32'd3);
    checkOutput("bp3_gap",   32'(c3 - c2), 32'd3);
    checkOutput("bp4_gap",   32'(c4 - c3), 32'd3);
    checkOutput("bp5_gap",   32'(c5 - c4), 32'd3);

    // Reset while the first of three queued commands is in WAIT
    $display("[TB] reset mid-operation");
    repeat (2) tick();
    applyStimulus(8'd1, 8'd1, 2'b00, 4'd1);
    applyStimulus(8'd2, 8'd2, 2'b00, 4'd2);
    applyStimulus(8'd3, 8'd3, 2'b00, 4'd3);
    qsize = rsp_q.size();
    reset = 1'b1;
    tick();
    checkOutput("rst_cmd_ready_high", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkAllZero("midrst");
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (10) tick();
    checkOutput("midrst_no_rsp", 32'(rsp_q.size()), 32'(qsize));
    checkOutput("midrst_idle_busy", 32'(busy), 32'd0);
    applyStimulus(8'd12, 8'd12, 2'b10, 4'd5);
    start_cyc = accept_cyc;
    waitResponses(1);
    expectRsp("after_rst", 16'd144, 4'd5, 1'b0, c1);
    checkOutput("after_rst_latency", 32'(c1 - start_cyc), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Command front-end for the registered 8-bit calculator block. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the calculator's operand/opcode inputs and captures the registered 16-bit result. It returns that result, tagged, over a second valid/ready handshake. Divide-by-zero is detected locally and never issued.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries. Power of two, ≥2.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `cmd_valid`, input, 1: command offered.
- `cmd_ready`, output, 1: FIFO can accept. Equals `!full && !reset`.
- `cmd_a`, input, 8: first operand, unsigned.
- `cmd_b`, input, 8: second operand, unsigned.
- `cmd_op`, input, 2: opcode. 00 add, 01 sub, 10 mul, 11 div.
- `cmd_tag`, input, 4: opaque ID, returned with the result.
- `alu_a`, output, 8: to the calculator's first operand. Registered.
- `alu_b`, output, 8: to the calculator's second operand. Registered.
- `alu_op`, output, 2: to the calculator's opcode. Registered.
- `alu_q`, input, 16: registered result from the calculator. The calculator is on the same `clk`/`reset`.
- `rsp_valid`, output, 1: result available.
- `rsp_ready`, input, 1: consumer accepts.
- `rsp_data`, output, 16: result.
- `rsp_tag`, output, 4: tag of the command.
- `rsp_err`, output, 1: 1 means divide-by-zero. `rsp_data` is then 16'hFFFF.
- `busy`, output, 1: high when FSM ≠ IDLE or FIFO non-empty.

## Operation
- **Push.** A command is pushed on a rising edge when `cmd_valid && cmd_ready`. It is stored as {a, b, op, tag}.
- **FSM states.** IDLE, ISSUE, WAIT, RESP.
- **IDLE.**
  - FIFO non-empty: pop the head.
  - If op=11 and b=0: load the rsp registers with data=16'hFFFF, err=1, tag. Go to RESP. The ALU outputs are unchanged.
  - Otherwise: load `alu_a`/`alu_b`/`alu_op`. Go to ISSUE.
- **ISSUE.** Operands are stable on the calculator inputs. The calculator latches Q at the end of this cycle. Go to WAIT.
- **WAIT.**
  - `alu_q` is valid. Capture it into `rsp_data`, with err=0 and the stored tag. Go to RESP.
  - `alu_*` are held through WAIT.
- **RESP.**
  - `rsp_valid`=1. Data, tag and err are held stable until `rsp_valid && rsp_ready`.
  - On handshake with FIFO non-empty: pop immediately, with the same branching as IDLE, going to ISSUE or RESP.
  - On handshake with FIFO empty: go to IDLE.
- **Result values.** Arithmetic happens in the calculator, not here. `rsp_data` is `alu_q` verbatim. Sub is 16-bit two's-complement wrap, e.g. 3−5 = 16'hFFFE. Mul is a full 16-bit result. Div truncates.
- **FIFO.** In-order. Push and pop in the same cycle are allowed when the FIFO is non-empty and not full; the count is unchanged. A push while full is impossible because `cmd_ready`=0. Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Reset (synchronous).** Applies at any point, including mid-ISSUE/WAIT/RESP.
  - FIFO is flushed and its pointers and count cleared.
  - FSM goes to IDLE.
  - `alu_a`, `alu_b`, `alu_op`: 0.
  - `rsp_valid`, `rsp_data`, `rsp_tag`, `rsp_err`: 0.
  - `busy`: 0.
  - `cmd_ready`: 0 while reset is high, 1 on the first cycle after.
  - In-flight and queued commands are dropped with no response.

## Timing
- Command accepted at edge N with the FIFO empty and FSM in IDLE:
  - pop and load `alu_*` at N+1;
  - calculator Q valid at N+2;
  - `rsp_valid` high after N+3.
- Divide-by-zero: `rsp_valid` high after N+1.
- Sustained throughput with `rsp_ready` tied high: one result per 3 cycles. Each RESP handshake overlaps the next pop.
- `rsp_valid` never drops without a handshake or reset.
- `cmd_ready` depends only on the count and `reset`, never on `cmd_valid`.

## Structure
- **Shared package `calc_pkg`:**
  - opcode enum: `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`;
  - FSM state enum;
  - `DIV0_RESULT` = 16'hFFFF;
  - operand width 8 and result width 16 constants;
  - packed command struct {a, b, op, tag}.
- **Sub-module `calc_cmd_fifo`.** Synchronous FIFO of the command struct, parameterised by depth. Outputs `full`, `empty`, `count`, and the head entry.
- **Top level.** FSM, ALU operand registers and response registers.
- **Bench.** Instantiates the existing calculator as the DUT's ALU.

## Test plan
- **Single add.** Push a=200, b=100, op=00, tag=3, `rsp_ready`=1. Expect `rsp_valid` 3 cycles after accept, data=16'd300, tag=3, err=0.
- **Sub and mul, in order.** Push sub a=3, b=5, tag=1, then mul a=255, b=255, tag=2. Expect 16'hFFFE tag 1, then 16'hFE01 tag 2.
- **Divide-by-zero, mixed.** Push div a=9, b=0, tag=7, then div a=9, b=2, tag=8. Expect FFFF err=1 tag 7 one cycle after pop, then 16'd4 err=0 tag 8. ALU outputs do not change for tag 7.
- **Backpressure.** Hold `rsp_ready`=0 and push 5 commands (`FIFO_DEPTH`=4). Expect `cmd_ready`=0 once the FIFO holds 4 plus one in RESP, and rsp fields stable. Release `rsp_ready`: all 5 results in order, one per 3 cycles.
- **Reset mid-operation.** Queue 3 commands, assert `reset` for 1 cycle while in WAIT. Expect all outputs 0, no responses, `busy`=0, `cmd_ready`=1 on the next cycle. A new command then completes normally.
